snail_scan_ctrl: RTL

Scan controller for the snail-style serial sequence detector. Latches a parallel word and a programmable bit pattern, then shifts the word MSB-first, one bit per clock, through an internal detector core. It counts overlapping pattern matches and records the first match position. A start/busy/done handshake lets a host or testbench launch scans back-to-back and read the results.

---
 rtl/snail_scan_ctrl_pkg.sv | 13 +
 rtl/snail_scan_ctrl_det_core.sv | 49 ++++
 rtl/snail_scan_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/snail_scan_ctrl_pkg.sv
// Shared types for the snail scan controller.
// State encoding is fixed binary: IDLE=0, SHIFT=1, DONE=2.
package snail_scan_ctrl_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/snail_scan_ctrl_det_core.sv
// Serial pattern detector core: history, fill count,
// window compare and registered match flag.
module snail_det_core
  import snail_scan_ctrl_pkg::*;
#(
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         _rst,
  input  logic         clr,
  input  logic         en,
  input  logic         bit_in,
  input  logic [P-1:0] pat,
  output logic         m,
  output logic         det_q
);

  localparam int FW = $clog2(P + 1);
  localparam logic [FW-1:0] FMAX = FW'(P);
  localparam logic [FW-1:0] FTH  = FW'(P - 1);

  logic [P-2:0]  hist;
  logic [FW-1:0] fill;
  logic [P-1:0]  win;

  assign win = {hist, bit_in};
  assign m   = (win == pat) && (fill >= FTH);

  // History survives a match so overlapping hits count.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      hist  <= '0;
      fill  <= '0;
      det_q <= 1'b0;
    end else if (clr) begin
      hist  <= '0;
      fill  <= '0;
      det_q <= 1'b0;
    end else begin
      det_q <= en & m;
      if (en) begin
        hist <= win[P-2:0];
        if (fill != FMAX)
          fill <= fill + FW'(1);
      end
    end
  end

endmodule

// File: rtl/snail_scan_ctrl.sv
// Scan controller: latches a word and pattern, shifts the
// word MSB-first through the detector and tallies matches.
module snail_scan_ctrl
  import snail_scan_ctrl_pkg::*;
#(
  parameter int W     = 16,
  parameter int P     = 4,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             start,
  input  logic             abort,
  input  logic [W-1:0]     word,
  input  logic [P-1:0]     pattern,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] first_pos,
  output logic             found,
  output logic             ser_bit,
  output logic             det_q
);

  state_t st, st_d;

  logic [W-1:0]     word_reg;
  logic [W-1:0]     sh;
  logic [P-1:0]     pat_reg;
  logic [CNT_W-1:0] k;
  logic acc, step, last, en, m;

  assign busy = (st == S_SHIFT);
  assign done = (st == S_DONE);
  assign acc  = start && (st == S_IDLE || st == S_DONE);
  assign step = busy && !abort;
  assign last = (k == CNT_W'(W - 1));

  // The final bit still counts, but det_q must fall
  // on the edge that leaves SHIFT.
  assign en = step && !last;

  assign sh      = word_reg << k;
  assign ser_bit = busy & sh[W-1];

  snail_det_core #(.P(P)) u_det (
    .clk    (clk),
    ._rst   (_rst),
    .clr    (acc),
    .en     (en),
    .bit_in (ser_bit),
    .pat    (pat_reg),
    .m      (m),
    .det_q  (det_q)
  );

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) st <= S_IDLE;
    else       st <= st_d;
  end

  always_comb begin
    st_d = st;
    unique case (st)
      S_IDLE: begin
        if (start) st_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (abort)     st_d = S_IDLE;
        else if (last) st_d = S_DONE;
      end
      S_DONE: begin
        st_d = start ? S_SHIFT : S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      word_reg  <= '0;
      pat_reg   <= '0;
      k         <= '0;
      match_cnt <= '0;
      first_pos <= '0;
      found     <= 1'b0;
    end else if (acc) begin
      word_reg  <= word;
      pat_reg   <= pattern;
      k         <= '0;
      match_cnt <= '0;
      first_pos <= '0;
      found     <= 1'b0;
    end else if (step) begin
      if (m) begin
        match_cnt <= match_cnt + CNT_W'(1);
        if (!found) begin
          first_pos <= k;
          found     <= 1'b1;
        end
      end
      if (!last)
        k <= k + CNT_W'(1);
    end
  end

endmodule
